// File: rtl/pi1_to_axi4_dw.sv
// rtl/pi1_to_axi4_dw.sv - PI1 slave to single-beat AXI4 manager bridge with data-width lane steering
module pi1_to_axi4_dw #(
    parameter int ARCHBITSZ       = 32,
    parameter int AXI4_DATA_WIDTH = 64,
    parameter int AXI4_ID_WIDTH   = 4,
    parameter int AXI4_ID         = 0
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,

    input  logic [1:0]                                pi1_op_i,
    input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]  pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]                      pi1_data_i,
    output logic [ARCHBITSZ-1:0]                      pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0]                    pi1_sel_i,
    output logic                                      pi1_rdy_o,
    output logic                                      pi1_err_o,

    output logic [AXI4_ID_WIDTH-1:0]                  axi4_awid_o,
    output logic [ARCHBITSZ-1:0]                      axi4_awaddr_o,
    output logic [7:0]                                axi4_awlen_o,
    output logic [2:0]                                axi4_awsize_o,
    output logic [1:0]                                axi4_awburst_o,
    output logic                                      axi4_awlock_o,
    output logic [3:0]                                axi4_awcache_o,
    output logic [2:0]                                axi4_awprot_o,
    output logic [3:0]                                axi4_awqos_o,
    output logic                                      axi4_awvalid_o,
    input  logic                                      axi4_awready_i,

    output logic [AXI4_DATA_WIDTH-1:0]                axi4_wdata_o,
    output logic [AXI4_DATA_WIDTH/8-1:0]              axi4_wstrb_o,
    output logic                                      axi4_wlast_o,
    output logic                                      axi4_wvalid_o,
    input  logic                                      axi4_wready_i,

    output logic                                      axi4_bready_o,
    input  logic [AXI4_ID_WIDTH-1:0]                  axi4_bid_i,
    input  logic [1:0]                                axi4_bresp_i,
    input  logic                                      axi4_bvalid_i,

    output logic [AXI4_ID_WIDTH-1:0]                  axi4_arid_o,
    output logic [ARCHBITSZ-1:0]                      axi4_araddr_o,
    output logic [7:0]                                axi4_arlen_o,
    output logic [2:0]                                axi4_arsize_o,
    output logic [1:0]                                axi4_arburst_o,
    output logic                                      axi4_arlock_o,
    output logic [3:0]                                axi4_arcache_o,
    output logic [2:0]                                axi4_arprot_o,
    output logic [3:0]                                axi4_arqos_o,
    output logic                                      axi4_arvalid_o,
    input  logic                                      axi4_arready_i,

    output logic                                      axi4_rready_o,
    input  logic [AXI4_ID_WIDTH-1:0]                  axi4_rid_i,
    input  logic [AXI4_DATA_WIDTH-1:0]                axi4_rdata_i,
    input  logic [1:0]                                axi4_rresp_i,
    input  logic                                      axi4_rlast_i,
    input  logic                                      axi4_rvalid_i
);

    localparam int WORD_BYTES = ARCHBITSZ / 8;
    localparam int ADDR_LSB   = $clog2(WORD_BYTES);
    localparam int LANES      = AXI4_DATA_WIDTH / ARCHBITSZ;
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] OP_NOOP = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;

    logic [2:0]              state;
    logic [ARCHBITSZ-1:0]    addr_q;
    logic [ARCHBITSZ-1:0]    data_q;
    logic [WORD_BYTES-1:0]   sel_q;
    logic [LANE_W-1:0]       lane_q;
    logic [ARCHBITSZ-1:0]    rmw_data_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    arvalid_q;

    logic [ADDR_LSB-1:0]     sel_lsb;
    logic [LANE_W-1:0]       lane_next;
    logic [ARCHBITSZ-1:0]    lane_rdata;
    logic                    in_rd;
    logic                    in_wr;
    logic                    r_hs;
    logic                    b_hs;
    logic                    complete;
    logic                    accept;

    // Byte offset inside the word comes from the lowest enabled byte lane
    always_comb begin
        sel_lsb = '0;
        for (int i = WORD_BYTES - 1; i >= 0; i--) begin
            if (pi1_sel_i[i]) sel_lsb = ADDR_LSB'(i);
        end
    end

    assign lane_next  = (LANES > 1) ? pi1_addr_i[LANE_W-1:0] : '0;
    assign lane_rdata = axi4_rdata_i[int'(lane_q)*ARCHBITSZ +: ARCHBITSZ];

    assign in_rd = (state == S_RD) || (state == S_RMW_RD);
    assign in_wr = (state == S_WR) || (state == S_RMW_WR);
    assign r_hs  = in_rd && axi4_rvalid_i;
    // A B response only counts once both AW and W have been accepted
    assign b_hs  = in_wr && axi4_bvalid_i && !awvalid_q && !wvalid_q;

    assign complete = ((state == S_RD) && r_hs)
                    || ((state == S_RMW_RD) && r_hs && axi4_rresp_i[1])
                    || b_hs;

    assign pi1_rdy_o = (state == S_IDLE) || complete;
    assign pi1_err_o = (r_hs && axi4_rresp_i[1]) || (b_hs && axi4_bresp_i[1]);
    assign accept    = pi1_rdy_o && (pi1_op_i != OP_NOOP);

    always_comb begin
        pi1_data_o = '0;
        if ((state == S_RD) && r_hs) pi1_data_o = lane_rdata;
        else if ((state == S_RMW_WR) && b_hs) pi1_data_o = rmw_data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            lane_q     <= '0;
            rmw_data_q <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
        end else begin
            if (arvalid_q && axi4_arready_i) arvalid_q <= 1'b0;
            if (awvalid_q && axi4_awready_i) awvalid_q <= 1'b0;
            if (wvalid_q && axi4_wready_i)   wvalid_q  <= 1'b0;

            if ((state == S_RMW_RD) && r_hs && !axi4_rresp_i[1]) begin
                state      <= S_RMW_WR;
                rmw_data_q <= lane_rdata;
                awvalid_q  <= 1'b1;
                wvalid_q   <= 1'b1;
            end

            if (accept) begin
                addr_q <= {pi1_addr_i, sel_lsb};
                data_q <= pi1_data_i;
                sel_q  <= pi1_sel_i;
                lane_q <= lane_next;
                if (pi1_op_i == OP_WR) begin
                    state     <= S_WR;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                end else begin
                    state     <= (pi1_op_i == OP_RD) ? S_RD : S_RMW_RD;
                    arvalid_q <= 1'b1;
                end
            end else if (complete) begin
                state <= S_IDLE;
            end
        end
    end

    always_comb begin
        axi4_wstrb_o = '0;
        axi4_wstrb_o[int'(lane_q)*WORD_BYTES +: WORD_BYTES] = sel_q;
    end

    assign axi4_wdata_o   = {LANES{data_q}};
    assign axi4_wlast_o   = wvalid_q;
    assign axi4_wvalid_o  = wvalid_q;
    assign axi4_bready_o  = in_wr;
    assign axi4_rready_o  = in_rd;

    assign axi4_awid_o    = AXI4_ID_WIDTH'(AXI4_ID);
    assign axi4_awaddr_o  = addr_q;
    assign axi4_awlen_o   = 8'd0;
    assign axi4_awsize_o  = 3'(ADDR_LSB);
    assign axi4_awburst_o = 2'b01;
    assign axi4_awlock_o  = 1'b0;
    assign axi4_awcache_o = 4'd0;
    assign axi4_awprot_o  = 3'd0;
    assign axi4_awqos_o   = 4'd0;
    assign axi4_awvalid_o = awvalid_q;

    assign axi4_arid_o    = AXI4_ID_WIDTH'(AXI4_ID);
    assign axi4_araddr_o  = addr_q;
    assign axi4_arlen_o   = 8'd0;
    assign axi4_arsize_o  = 3'(ADDR_LSB);
    assign axi4_arburst_o = 2'b01;
    assign axi4_arlock_o  = 1'b0;
    assign axi4_arcache_o = 4'd0;
    assign axi4_arprot_o  = 3'd0;
    assign axi4_arqos_o   = 4'd0;
    assign axi4_arvalid_o = arvalid_q;

    // Single outstanding transaction: IDs, rlast and the low resp bit carry no information here
    logic unused_inputs;
    assign unused_inputs = ^{axi4_bid_i, axi4_rid_i, axi4_rlast_i, axi4_bresp_i[0], axi4_rresp_i[0]};

endmodule

// File: tb/tb_pi1_to_axi4_dw.sv
// tb/tb_pi1_to_axi4_dw.sv - directed self-checking bench for pi1_to_axi4_dw (32-bit PI1, 64-bit AXI)
module tb_pi1_to_axi4_dw;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  pi1_op_i;
    logic [29:0] pi1_addr_i;
    logic [31:0] pi1_data_i;
    logic [31:0] pi1_data_o;
    logic [3:0]  pi1_sel_i;
    logic        pi1_rdy_o;
    logic        pi1_err_o;

    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock;
    logic [3:0]  awcache, arcache, awqos, arqos;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic        bready, bvalid, arvalid, arready, rready, rlast, rvalid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    pi1_to_axi4_dw #(.ARCHBITSZ(32), .AXI4_DATA_WIDTH(64), .AXI4_ID_WIDTH(4), .AXI4_ID(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pi1_op_i(pi1_op_i), .pi1_addr_i(pi1_addr_i), .pi1_data_i(pi1_data_i),
        .pi1_data_o(pi1_data_o), .pi1_sel_i(pi1_sel_i), .pi1_rdy_o(pi1_rdy_o), .pi1_err_o(pi1_err_o),
        .axi4_awid_o(awid), .axi4_awaddr_o(awaddr), .axi4_awlen_o(awlen), .axi4_awsize_o(awsize),
        .axi4_awburst_o(awburst), .axi4_awlock_o(awlock), .axi4_awcache_o(awcache),
        .axi4_awprot_o(awprot), .axi4_awqos_o(awqos), .axi4_awvalid_o(awvalid), .axi4_awready_i(awready),
        .axi4_wdata_o(wdata), .axi4_wstrb_o(wstrb), .axi4_wlast_o(wlast), .axi4_wvalid_o(wvalid),
        .axi4_wready_i(wready),
        .axi4_bready_o(bready), .axi4_bid_i(bid), .axi4_bresp_i(bresp), .axi4_bvalid_i(bvalid),
        .axi4_arid_o(arid), .axi4_araddr_o(araddr), .axi4_arlen_o(arlen), .axi4_arsize_o(arsize),
        .axi4_arburst_o(arburst), .axi4_arlock_o(arlock), .axi4_arcache_o(arcache),
        .axi4_arprot_o(arprot), .axi4_arqos_o(arqos), .axi4_arvalid_o(arvalid), .axi4_arready_i(arready),
        .axi4_rready_o(rready), .axi4_rid_i(rid), .axi4_rdata_i(rdata), .axi4_rresp_i(rresp),
        .axi4_rlast_i(rlast), .axi4_rvalid_i(rvalid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] op, input logic [29:0] addr, input logic [3:0] sel, input logic [31:0] data);
        pi1_op_i = op; pi1_addr_i = addr; pi1_sel_i = sel; pi1_data_i = data;
    endtask

    initial begin
        rst_i = 1'b1;
        req(2'b00, '0, '0, '0);
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_rdy", pi1_rdy_o, 1);
        chk("rst_err", pi1_err_o, 0);
        chk("rst_data", pi1_data_o, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("const_fields", {awlen, awsize, awburst, arsize, arburst, awid, wlast}, {8'd0, 3'd2, 2'b01, 3'd2, 2'b01, 4'd0, 1'b0});

        // WR addr 3: AW accepted after 3 cycles, W immediately
        @(negedge clk_i);
        req(2'b01, 30'h3, 4'hF, 32'hDEADBEEF); wready = 1;
        #1 chk("wr_accept_rdy", pi1_rdy_o, 1);
        @(negedge clk_i);
        req(2'b00, '0, '0, '0);
        #1;
        chk("wr_awvalid_c1", awvalid, 1);
        chk("wr_wvalid_c1", wvalid, 1);
        chk("wr_awaddr", awaddr, 32'hC);
        chk("wr_wstrb", wstrb, 8'hF0);
        chk("wr_wdata", wdata, 64'hDEADBEEF_DEADBEEF);
        chk("wr_bready", bready, 1);
        chk("wr_rdy_busy", pi1_rdy_o, 0);
        @(negedge clk_i);
        bvalid = 1;
        #1;
        chk("wr_wvalid_dropped", wvalid, 0);
        chk("wr_awvalid_c2", awvalid, 1);
        chk("wr_early_b_ignored", {pi1_rdy_o, pi1_err_o}, 2'b00);
        @(negedge clk_i);
        bvalid = 0; awready = 1;
        #1 chk("wr_awvalid_c3", awvalid, 1);
        @(negedge clk_i);
        awready = 0; wready = 0; bvalid = 1;
        #1;
        chk("wr_awvalid_dropped", awvalid, 0);
        chk("wr_b_rdy", pi1_rdy_o, 1);
        chk("wr_b_err", pi1_err_o, 0);
        chk("wr_b_data", pi1_data_o, 0);
        @(negedge clk_i);
        bvalid = 0;
        #1;
        chk("wr_idle_rdy", pi1_rdy_o, 1);
        chk("wr_idle_bready", bready, 0);

        // RD addr 2 (lane 0) then back-to-back RD addr 3 (lane 1)
        req(2'b10, 30'h2, 4'hF, 32'h0);
        @(negedge clk_i);
        req(2'b00, '0, '0, '0); arready = 1;
        #1;
        chk("rd0_arvalid", arvalid, 1);
        chk("rd0_araddr", araddr, 32'h8);
        chk("rd0_rready", rready, 1);
        chk("rd0_rdy_busy", pi1_rdy_o, 0);
        @(negedge clk_i);
        arready = 0; rvalid = 1; rdata = 64'h11112222_33334444;
        req(2'b10, 30'h3, 4'hF, 32'h0);
        #1;
        chk("rd0_arvalid_dropped", arvalid, 0);
        chk("rd0_rdy", pi1_rdy_o, 1);
        chk("rd0_data", pi1_data_o, 32'h33334444);
        chk("rd0_err", pi1_err_o, 0);
        @(negedge clk_i);
        rvalid = 0; req(2'b00, '0, '0, '0); arready = 1;
        #1;
        chk("rd1_data_idle", pi1_data_o, 0);
        chk("rd1_arvalid", arvalid, 1);
        chk("rd1_araddr", araddr, 32'hC);
        @(negedge clk_i);
        arready = 0; rvalid = 1;
        req(2'b01, 30'h0, 4'hF, 32'h12345678);
        #1;
        chk("rd1_data", pi1_data_o, 32'h11112222);
        chk("rd1_rdy", pi1_rdy_o, 1);

        // WR accepted in the RD completion cycle, finishes with SLVERR
        @(negedge clk_i);
        rvalid = 0; req(2'b00, '0, '0, '0); awready = 1; wready = 1;
        #1;
        chk("b2b_awvalid", awvalid, 1);
        chk("b2b_wvalid", wvalid, 1);
        chk("b2b_awaddr", awaddr, 32'h0);
        chk("b2b_wstrb", wstrb, 8'h0F);
        @(negedge clk_i);
        awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
        #1;
        chk("b2b_valids_dropped", {awvalid, wvalid}, 2'b00);
        chk("b2b_slverr", {pi1_rdy_o, pi1_err_o}, 2'b11);
        @(negedge clk_i);
        bvalid = 0; bresp = 0;

        // RW addr 5 sel 3: read lane 1, then write lane 1
        req(2'b11, 30'h5, 4'h3, 32'h0000AAAA);
        @(negedge clk_i);
        req(2'b00, '0, '0, '0); arready = 1;
        #1;
        chk("rmw_arvalid", arvalid, 1);
        chk("rmw_araddr", araddr, 32'h14);
        chk("rmw_no_aw_yet", awvalid, 0);
        @(negedge clk_i);
        arready = 0; rvalid = 1; rdata = 64'hCAFEF00D_00000000; rresp = 0;
        #1 chk("rmw_r_not_done", pi1_rdy_o, 0);
        @(negedge clk_i);
        rvalid = 0; awready = 1; wready = 1;
        #1;
        chk("rmw_awvalid", awvalid, 1);
        chk("rmw_awaddr", awaddr, 32'h14);
        chk("rmw_wstrb", wstrb, 8'h30);
        chk("rmw_wdata", wdata, 64'h0000AAAA_0000AAAA);
        chk("rmw_rdy_busy", pi1_rdy_o, 0);
        @(negedge clk_i);
        awready = 0; wready = 0; bvalid = 1;
        #1;
        chk("rmw_b_rdy", pi1_rdy_o, 1);
        chk("rmw_b_data", pi1_data_o, 32'hCAFEF00D);
        chk("rmw_b_err", pi1_err_o, 0);
        @(negedge clk_i);
        bvalid = 0;

        // RW whose read returns SLVERR: no write phase
        req(2'b11, 30'h1, 4'hF, 32'h0);
        @(negedge clk_i);
        req(2'b00, '0, '0, '0); arready = 1;
        @(negedge clk_i);
        arready = 0; rvalid = 1; rresp = 2'b10;
        #1 chk("rmwerr_r_cycle", {pi1_rdy_o, pi1_err_o}, 2'b11);
        @(negedge clk_i);
        rvalid = 0; rresp = 0;
        #1;
        chk("rmwerr_no_aw", {awvalid, wvalid}, 2'b00);
        chk("rmwerr_idle", pi1_rdy_o, 1);
        @(negedge clk_i);
        #1 chk("rmwerr_no_aw_later", awvalid, 0);

        // Reset asserted mid-cycle while AW is pending
        req(2'b01, 30'h7, 4'hF, 32'h55);
        @(negedge clk_i);
        req(2'b00, '0, '0, '0);
        #1 chk("rst_wr_awvalid", awvalid, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid_valids", {awvalid, wvalid, bready}, 3'b000);
        chk("rst_mid_rdy", pi1_rdy_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        req(2'b10, 30'h4, 4'hF, 32'h0);
        @(negedge clk_i);
        req(2'b00, '0, '0, '0); arready = 1;
        #1;
        chk("post_rst_arvalid", arvalid, 1);
        chk("post_rst_araddr", araddr, 32'h10);
        @(negedge clk_i);
        arready = 0; rvalid = 1; rdata = 64'hAAAABBBB_CCCCDDDD;
        #1 chk("post_rst_data", pi1_data_o, 32'hCCCCDDDD);
        @(negedge clk_i);
        rvalid = 0;
        #1;
        chk("post_rst_idle_rdy", pi1_rdy_o, 1);
        chk("post_rst_idle_data", pi1_data_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
